// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths and result-entry type for the ALU result stage
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int DEST_W = 5;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              z;
        logic              n;
        logic [DEST_W-1:0] dest;
        logic              flag_we;
    } entry_t;

endpackage

// File: rtl/alu_result_fifo2.sv
// rtl/alu_result_fifo2.sv - 2-deep valid/ready FIFO of entries, no bypass
module alu_result_fifo2 #(
    parameter type T = alu_pkg::entry_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    T           head;
    T           tail;
    logic [1:0] count;
    logic       push;
    logic       pop;

    // Ready looks only at registered occupancy, so nothing combinational reaches back from out_ready.
    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = head;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else begin
            if (pop) begin
                if (count == 2'd2) begin
                    head <= tail;
                end else if (push) begin
                    head <= in_data;
                end
            end else if (push) begin
                if (count == 2'd0) begin
                    head <= in_data;
                end else begin
                    tail <= in_data;
                end
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// rtl/alu_result_stage.sv - buffered ALU result/flag stage: writeback port, Z/N retirement, flag check, retire counter
module alu_result_stage #(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int DEST_W = alu_pkg::DEST_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic              in_z,
    input  logic              in_n,
    input  logic [DEST_W-1:0] in_dest,
    input  logic              in_flag_we,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [DEST_W-1:0] out_dest,
    output logic              status_z,
    output logic              status_n,
    output logic              flag_err,
    output logic [CNT_W-1:0]  retire_cnt
);

    import alu_pkg::*;

    entry_t in_entry;
    entry_t head;
    logic   push;
    logic   pop;
    logic   z_bad;
    logic   n_bad;

    always_comb begin
        in_entry         = '0;
        in_entry.result  = in_result;
        in_entry.z       = in_z;
        in_entry.n       = in_n;
        in_entry.dest    = in_dest;
        in_entry.flag_we = in_flag_we;
    end

    alu_result_fifo2 #(.T(entry_t)) fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head)
    );

    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;
    assign out_result = head.result;
    assign out_dest   = head.dest;

    // Producer flags are only audited; the entry keeps them as delivered.
    assign z_bad = (in_z != (in_result == '0));
    assign n_bad = (in_n != in_result[DATA_W-1]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            status_z   <= 1'b0;
            status_n   <= 1'b0;
            flag_err   <= 1'b0;
            retire_cnt <= '0;
        end else begin
            if (pop && head.flag_we) begin
                status_z <= head.z;
                status_n <= head.n;
            end
            if (pop) begin
                retire_cnt <= retire_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (push && (z_bad || n_bad)) begin
                flag_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// tb/tb_alu_result_stage.sv - self-checking bench for alu_result_stage against a queue-based model
module tb_alu_result_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic        in_z;
    logic        in_n;
    logic [4:0]  in_dest;
    logic        in_flag_we;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_dest;
    logic        status_z;
    logic        status_n;
    logic        flag_err;
    logic [15:0] retire_cnt;

    logic        in_ready4;
    logic        out_valid4;
    logic [31:0] out_result4;
    logic [4:0]  out_dest4;
    logic        status_z4;
    logic        status_n4;
    logic        flag_err4;
    logic [3:0]  retire_cnt4;

    alu_result_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_z(in_z), .in_n(in_n), .in_dest(in_dest),
        .in_flag_we(in_flag_we), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_dest(out_dest), .status_z(status_z),
        .status_n(status_n), .flag_err(flag_err), .retire_cnt(retire_cnt)
    );

    alu_result_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .in_result(in_result), .in_z(in_z), .in_n(in_n), .in_dest(in_dest),
        .in_flag_we(in_flag_we), .out_valid(out_valid4), .out_ready(out_ready),
        .out_result(out_result4), .out_dest(out_dest4), .status_z(status_z4),
        .status_n(status_n4), .flag_err(flag_err4), .retire_cnt(retire_cnt4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] result;
        logic        z;
        logic        n;
        logic [4:0]  dest;
        logic        we;
    } ment_t;

    ment_t q[$];
    logic  m_z;
    logic  m_n;
    logic  m_err;
    int    m_cnt;
    int    errors = 0;
    int    checks = 0;

    // Advance one clock edge and apply the architectural rules to the model.
    task automatic cycle();
        ment_t e;
        bit    do_push;
        bit    do_pop;
        do_push = rst_n && in_valid && (q.size() < 2);
        do_pop  = rst_n && (q.size() > 0) && out_ready;
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            m_z = 1'b0; m_n = 1'b0; m_err = 1'b0; m_cnt = 0;
        end else begin
            if (do_pop) begin
                e = q.pop_front();
                if (e.we) begin
                    m_z = e.z;
                    m_n = e.n;
                end
                m_cnt++;
            end
            if (do_push) begin
                e.result = in_result; e.z = in_z; e.n = in_n;
                e.dest = in_dest; e.we = in_flag_we;
                if ((in_z != (in_result == 32'h0)) || (in_n != in_result[31])) m_err = 1'b1;
                q.push_back(e);
            end
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] r, input logic z, input logic n,
                         input logic [4:0] d, input logic we);
        in_valid = v; in_result = r; in_z = z; in_n = n; in_dest = d; in_flag_we = we;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 5'h0, 1'b0);
        out_ready = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_result !== 32'h0) begin errors++; $display("FAIL reset_out_result got=%h exp=0", out_result); end
        checks++; if (out_dest !== 5'h0) begin errors++; $display("FAIL reset_out_dest got=%h exp=0", out_dest); end
        checks++; if ({status_z, status_n, flag_err} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {status_z, status_n, flag_err}); end
        checks++; if (retire_cnt !== 16'h0) begin errors++; $display("FAIL reset_retire_cnt got=%0d exp=0", retire_cnt); end
    endtask

    task automatic test_single();
        do_reset();
        drive(1'b1, 32'h80000000, 1'b0, 1'b1, 5'd3, 1'b1);
        out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", out_valid); end
        checks++; if (out_result !== 32'h80000000) begin errors++; $display("FAIL single_result got=%h exp=80000000", out_result); end
        checks++; if (out_dest !== 5'd3) begin errors++; $display("FAIL single_dest got=%0d exp=3", out_dest); end
        cycle();
        checks++; if ({status_n, status_z} !== 2'b10) begin errors++; $display("FAIL single_status got=nz %b exp=10", {status_n, status_z}); end
        checks++; if (retire_cnt !== 16'd1) begin errors++; $display("FAIL single_cnt got=%0d exp=1", retire_cnt); end
        checks++; if (flag_err !== 1'b0) begin errors++; $display("FAIL single_err got=%b exp=0", flag_err); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_fill();
        do_reset();
        drive(1'b1, 32'h00008800, 1'b0, 1'b0, 5'd1, 1'b1);
        cycle();
        drive(1'b1, 32'h09008040, 1'b0, 1'b0, 5'd2, 1'b1);
        cycle();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready got=%b exp=0", in_ready); end
        drive(1'b1, 32'h00000001, 1'b0, 1'b0, 5'd9, 1'b1);
        cycle();
        in_valid = 1'b0;
        checks++; if (out_result !== 32'h00008800) begin errors++; $display("FAIL fill_hold got=%h exp=00008800", out_result); end
        out_ready = 1'b1;
        cycle();
        checks++; if (out_result !== 32'h09008040 || out_valid !== 1'b1) begin errors++; $display("FAIL fill_second got=%h v=%b exp=09008040 v=1", out_result, out_valid); end
        cycle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fill_third_dropped got=%b exp=0", out_valid); end
        checks++; if (retire_cnt !== 16'd2) begin errors++; $display("FAIL fill_cnt got=%0d exp=2", retire_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        do_reset();
        drive(1'b1, 32'h00000011, 1'b0, 1'b0, 5'd4, 1'b0);
        cycle();
        drive(1'b1, 32'h00000022, 1'b0, 1'b0, 5'd5, 1'b0);
        out_ready = 1'b1;
        cycle();
        checks++; if (out_result !== 32'h22 || out_valid !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL pushpop_head got=%h v=%b r=%b exp=22 1 1", out_result, out_valid, in_ready); end
        checks++; if (retire_cnt !== 16'd1) begin errors++; $display("FAIL pushpop_cnt got=%0d exp=1", retire_cnt); end
        for (int i = 0; i < 6; i++) begin
            v = 32'h100 + 32'(i);
            drive(1'b1, v, 1'b0, 1'b0, 5'(i), 1'b0);
            cycle();
            checks++; if (out_result !== v || out_valid !== 1'b1) begin errors++; $display("FAIL stream_%0d got=%h exp=%h", i, out_result, v); end
        end
        in_valid = 1'b0;
        cycle();
        checks++; if (retire_cnt !== 16'd8) begin errors++; $display("FAIL stream_cnt got=%0d exp=8", retire_cnt); end
    endtask

    task automatic test_flag_mismatch();
        do_reset();
        out_ready = 1'b1;
        drive(1'b1, 32'h0, 1'b1, 1'b0, 5'd1, 1'b1);
        cycle();
        in_valid = 1'b0;
        cycle();
        checks++; if (status_z !== 1'b1 || flag_err !== 1'b0) begin errors++; $display("FAIL mm_prep got=z%b e%b exp=z1 e0", status_z, flag_err); end
        out_ready = 1'b0;
        drive(1'b1, 32'h0, 1'b0, 1'b0, 5'd2, 1'b1);
        cycle();
        in_valid = 1'b0;
        checks++; if (flag_err !== 1'b1) begin errors++; $display("FAIL mm_err got=%b exp=1", flag_err); end
        out_ready = 1'b1;
        cycle();
        cycle();
        checks++; if (status_z !== 1'b0 || flag_err !== 1'b1) begin errors++; $display("FAIL mm_retire got=z%b e%b exp=z0 e1", status_z, flag_err); end
    endtask

    task automatic test_no_flag_we();
        do_reset();
        out_ready = 1'b1;
        drive(1'b1, 32'h80000000, 1'b0, 1'b1, 5'd1, 1'b1);
        cycle();
        drive(1'b1, 32'h0, 1'b1, 1'b0, 5'd2, 1'b0);
        cycle();
        in_valid = 1'b0;
        cycle();
        checks++; if ({status_z, status_n} !== 2'b01) begin errors++; $display("FAIL nowe_status got=zn %b exp=01", {status_z, status_n}); end
        checks++; if (retire_cnt !== 16'd2) begin errors++; $display("FAIL nowe_cnt got=%0d exp=2", retire_cnt); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b1;
        drive(1'b1, 32'h80000000, 1'b1, 1'b1, 5'd1, 1'b1);
        cycle();
        out_ready = 1'b0;
        drive(1'b1, 32'h5, 1'b0, 1'b0, 5'd2, 1'b1);
        cycle();
        drive(1'b1, 32'h6, 1'b0, 1'b0, 5'd3, 1'b1);
        cycle();
        checks++; if (in_ready !== 1'b0 || flag_err !== 1'b1) begin errors++; $display("FAIL mid_prep got=r%b e%b exp=r0 e1", in_ready, flag_err); end
        rst_n = 1'b0;
        out_ready = 1'b1;
        cycle();
        rst_n = 1'b1;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL mid_fifo got=v%b r%b exp=v0 r1", out_valid, in_ready); end
        checks++; if ({status_z, status_n, flag_err} !== 3'b000 || retire_cnt !== 16'h0) begin errors++; $display("FAIL mid_status got=%b cnt=%0d exp=000 cnt=0", {status_z, status_n, flag_err}, retire_cnt); end
    endtask

    task automatic test_wrap();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 32'h40 + 32'(i), 1'b0, 1'b0, 5'(i), 1'b1);
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        checks++; if (retire_cnt4 !== 4'd1) begin errors++; $display("FAIL wrap_cnt4 got=%0d exp=1", retire_cnt4); end
        checks++; if (retire_cnt !== 16'd17) begin errors++; $display("FAIL wrap_cnt16 got=%0d exp=17", retire_cnt); end
    endtask

    task automatic test_random();
        logic [31:0] r;
        logic        z;
        logic        n;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: r = 32'h0;
                1: r = 32'h80000000 | $urandom;
                default: r = $urandom;
            endcase
            z = (r == 32'h0);
            n = r[31];
            if ($urandom_range(0, 31) == 0) z = ~z;
            if ($urandom_range(0, 31) == 0) n = ~n;
            drive(1'($urandom), r, z, n, 5'($urandom), 1'($urandom));
            out_ready = 1'($urandom);
            rst_n = ($urandom_range(0, 99) != 0);
            cycle();
            checks++; if (out_valid !== (q.size() > 0)) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", i, out_valid, q.size() > 0); end
            checks++; if (in_ready !== (q.size() < 2)) begin errors++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", i, in_ready, q.size() < 2); end
            if (q.size() > 0) begin
                checks++; if (out_result !== q[0].result || out_dest !== q[0].dest) begin errors++; $display("FAIL rnd_head cyc=%0d got=%h/%0d exp=%h/%0d", i, out_result, out_dest, q[0].result, q[0].dest); end
            end
            checks++; if ({status_z, status_n, flag_err} !== {m_z, m_n, m_err}) begin errors++; $display("FAIL rnd_flags cyc=%0d got=%b exp=%b", i, {status_z, status_n, flag_err}, {m_z, m_n, m_err}); end
            checks++; if (retire_cnt !== m_cnt[15:0] || retire_cnt4 !== m_cnt[3:0]) begin errors++; $display("FAIL rnd_cnt cyc=%0d got=%0d/%0d exp=%0d", i, retire_cnt, retire_cnt4, m_cnt); end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        m_z = 1'b0; m_n = 1'b0; m_err = 1'b0; m_cnt = 0;
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_flag_mismatch();
        test_no_flag_we();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Registered result/flag stage directly downstream of the ALU shifters (arithmetic right shift, left shift) and the other ALU units. It accepts a 32-bit result with its Z/N flags, buffers up to two results behind a valid/ready handshake and drives the writeback port. It retires the architectural Z/N status flags, flags any inconsistent Z/N from the producing unit, and counts retired results.

## Interface
- DATA_W, 32: result width.
- DEST_W, 5: destination register index width.
- CNT_W, 16: retire counter width.

- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- in_valid  in  1  producer has a result.
- in_ready  out  1  stage can accept this cycle.
- in_result  in  DATA_W  ALU result (B from shifter).
- in_z  in  1  producer zero flag.
- in_n  in  1  producer negative flag.
- in_dest  in  DEST_W  destination register.
- in_flag_we  in  1  result updates status flags on retire.
- out_valid  out  1  head entry present.
- out_ready  in  1  writeback accepts head.
- out_result  out  DATA_W  head result.
- out_dest  out  DEST_W  head destination.
- status_z  out  1  architectural Z.
- status_n  out  1  architectural N.
- flag_err  out  1  sticky producer-flag mismatch.
- retire_cnt  out  CNT_W  retired results, wraps.

## Operation
- 2-entry FIFO. Each entry holds result, z, n, dest, flag_we. Internal count is 0..2.
- Push when in_valid && in_ready. in_ready = (count != 2). It depends on registered count only and has no combinational path from out_ready.
- Pop when out_valid && out_ready. out_valid = (count != 0). out_result/out_dest show the head entry.
- Push and pop in the same cycle with count 1: count stays 1, and the new entry becomes head next cycle. With count 2 no push is possible. With count 0 no pop is possible, because there is no bypass.
- On pop, if the head's flag_we = 1, status_z/status_n take the head's z/n on the next edge. If flag_we = 0, they hold.
- On push, check in_z against (in_result == 0) and in_n against in_result[DATA_W-1]. Any mismatch sets flag_err. It stays set until reset. The entry is still stored with the producer's flags unchanged.
- retire_cnt increments by 1 per pop. It wraps from 2^CNT_W-1 to 0.
- Inputs are ignored when in_ready = 0. When out_valid = 0, out_result/out_dest hold their last value and have no meaning.

## Timing
- Reset values: in_ready = 1 (the value after reset), out_valid = 0, out_result = 0, out_dest = 0, status_z = 0, status_n = 0, flag_err = 0, retire_cnt = 0, count = 0.
- Reset asserted mid-operation discards all buffered entries on that edge. No pop is counted and no flags are retired in that cycle.
- Latency: push at edge t gives out_valid = 1 after edge t, so the entry can pop at edge t+1 at the earliest.
- Status flags and retire_cnt change on the same edge as the pop.
- Throughput is 1 result/cycle while out_ready is held high.
- out_valid is held until the pop, and head contents stay stable while out_valid && !out_ready.

## Structure
- Shared package alu_pkg holds:
  - DATA_W and DEST_W defaults;
  - a result-entry struct typedef {result, z, n, dest, flag_we}.
- Natural sub-module: alu_result_fifo2, a generic 2-deep valid/ready FIFO of entry structs.
- Flag retirement, the consistency check and the counter stay in alu_result_stage.

## Test plan
- Reset, then single push: in_result = 32'h80000000, in_z = 0, in_n = 1, flag_we = 1, out_ready = 1.
  - Required: out_valid next cycle with out_result 32'h80000000.
  - After the pop edge: status_n = 1, status_z = 0, retire_cnt = 1, flag_err = 0.
- Fill with out_ready = 0: push 32'h00008800 then 32'h09008040.
  - Required: in_ready = 0 after the second push, and a third push of 32'h1 is ignored.
  - Raising out_ready then pops the two entries in order over 2 cycles, and retire_cnt = 2.
- Simultaneous push/pop at count 1: count stays 1, out_result changes to the new entry, no gap or loss.
- Flag mismatch: push 32'h00000000 with in_z = 0.
  - Required: flag_err = 1 next cycle and stays 1.
  - The entry still retires with status_z = 0.
- flag_we = 0: retire 32'h0 with z = 1.
  - Required: status_z/status_n unchanged, retire_cnt increments.
- Reset mid-stream with 2 entries buffered: next cycle out_valid = 0, in_ready = 1, and all status/counter outputs are 0.
- CNT_W = 4 build: 17 retires give retire_cnt = 1.
